// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } rx_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Start low, stop high, odd parity across data plus parity bit.
  function automatic logic frame_ok(input logic [10:0] f);
    return !f[0] && f[10] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO with an explicit occupancy counter.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  ps2_event_t                   din,
  output ps2_event_t                   dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  ps2_event_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full still succeeds.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_keyrx.sv
// PS/2 keyboard receiver: oversampled frame decode, E0/F0 prefix folding, event FIFO.
module ps2_keyrx
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned SYNC    = 2,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        kbdclk,
  input  logic                        dat,
  output logic [7:0]                  keycode,
  output logic                        ext,
  output logic                        brk,
  output logic                        valid,
  input  logic                        ready,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        frame_err,
  output logic                        ovf
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  rx_state_t     state, state_n;
  logic [SYNC-1:0] clk_sync, dat_sync;
  logic          kbd_prev;
  logic          fall;
  logic [10:0]   frame;
  logic [3:0]    bitcnt;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          ext_pend, brk_pend;
  logic          good, is_ext, is_brk, push_req;
  logic          full, empty;
  ps2_event_t    head;

  // Sync flops idle high so reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      kbd_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC-2:0], kbdclk};
      dat_sync <= {dat_sync[SYNC-2:0], dat};
      kbd_prev <= clk_sync[SYNC-1];
    end
  end

  assign fall    = kbd_prev && !clk_sync[SYNC-1];
  assign timeout = (state == SHIFT) && !fall && (tcnt == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fall) state_n = SHIFT;
      SHIFT:   if (fall && bitcnt == 4'd10) state_n = CHECK;
               else if (timeout)            state_n = IDLE;
      CHECK:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    good      = frame_ok(frame);
    is_ext    = (frame[8:1] == PS2_EXT);
    is_brk    = (frame[8:1] == PS2_BRK);
    push_req  = (state == CHECK) && good && !is_ext && !is_brk;
    frame_err = ((state == CHECK) && !good) || timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame    <= '0;
      bitcnt   <= '0;
      tcnt     <= '0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (fall) begin
            frame[0] <= dat_sync[SYNC-1];
            bitcnt   <= 4'd1;
          end
        end
        SHIFT: begin
          if (fall) begin
            frame[bitcnt] <= dat_sync[SYNC-1];
            bitcnt        <= bitcnt + 4'd1;
            tcnt          <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
          if (timeout) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        end
        CHECK: begin
          bitcnt <= '0;
          tcnt   <= '0;
          if (good && is_ext)      ext_pend <= 1'b1;
          else if (good && is_brk) brk_pend <= 1'b1;
          else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        end
        default: begin
          bitcnt <= '0;
          tcnt   <= '0;
        end
      endcase
    end
  end

  ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (ready),
    .din   ('{ext: ext_pend, brk: brk_pend, code: frame[8:1]}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign valid   = !empty;
  assign keycode = head.code;
  assign ext     = head.ext;
  assign brk     = head.brk;
  assign ovf     = push_req && full && !ready;

endmodule

// File: tb/tb_ps2_keyrx.sv
// Scoreboard bench for ps2_keyrx: directed PS/2 frames, monitor pops and compares events.
module tb_ps2_keyrx;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kbdclk = 1'b1;
  logic       dat = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] keycode;
  logic       ext, brk, valid, frame_err, ovf;
  logic [$clog2(DEPTH+1)-1:0] count;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ovf_cnt = 0;
  logic [9:0] sbq [$];

  ps2_keyrx #(.DEPTH(DEPTH), .SYNC(2), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kbdclk    (kbdclk),
    .dat       (dat),
    .keycode   (keycode),
    .ext       (ext),
    .brk       (brk),
    .valid     (valid),
    .ready     (ready),
    .count     (count),
    .frame_err (frame_err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head event is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got %0h expected none", {ext, brk, keycode});
      end else begin
        logic [9:0] e;
        e = sbq.pop_front();
        if ({ext, brk, keycode} !== e) begin
          bad++;
          $display("FAIL event: got %0h expected %0h", {ext, brk, keycode}, e);
        end
      end
    end
    if (frame_err) fe_cnt++;
    if (ovf) ovf_cnt++;
  end

  function automatic logic [10:0] mkframe(input logic [7:0] b, input logic flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic ps2_bits(input logic [10:0] f, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      dat = f[i];
      repeat (4) @(posedge clk);
      #1 kbdclk = 1'b0;
      repeat (4) @(posedge clk);
      #1 kbdclk = 1'b1;
    end
    dat = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic flip);
    ps2_bits(mkframe(b, flip), 11);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input string name, input int n);
    for (int i = 0; i < 2000 && int'(count) != n; i++) @(negedge clk);
    check(name, 32'(count), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0;
    logic [7:0] codes [9];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

    repeat (3) @(negedge clk);
    check("reset_outs", {valid, ext, brk, keycode, frame_err, ovf}, 0);
    check("reset_count", 32'(count), 0);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Single key, held then popped.
    sbq.push_back({2'b00, 8'h1C});
    send(8'h1C, 1'b0);
    wait_count("one_count", 1);
    check("one_head", {ext, brk, keycode}, {2'b00, 8'h1C});
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    check("one_popped_valid", 32'(valid), 0);
    check("one_popped_count", 32'(count), 0);

    // Extended release folds into one event.
    ready = 1'b1;
    fe0 = fe_cnt;
    sbq.push_back({2'b11, 8'h74});
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h74, 1'b0);
    wait_count("ebrk_drain", 0);
    check("ebrk_no_ferr", 32'(fe_cnt - fe0), 0);

    // Bad parity discarded, next frame fine.
    fe0 = fe_cnt;
    sbq.push_back({2'b00, 8'h32});
    send(8'h1C, 1'b1);
    send(8'h32, 1'b0);
    wait_count("par_drain", 0);
    check("par_ferr", 32'(fe_cnt - fe0), 1);

    // Overflow: DEPTH+1 codes with no consumer.
    ready = 1'b0;
    ov0 = ovf_cnt;
    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) sbq.push_back({2'b00, codes[i]});
      send(codes[i], 1'b0);
    end
    @(negedge clk);
    check("full_count", 32'(count), DEPTH);
    check("full_ovf", 32'(ovf_cnt - ov0), 1);
    check("full_head", 32'(keycode), 32'h15);
    ready = 1'b1;
    wait_count("full_drain", 0);

    // Stalled frame times out, next frame received.
    fe0 = fe_cnt;
    ps2_bits(mkframe(8'h11, 1'b0), 5);
    repeat (TO + 30) @(posedge clk);
    @(negedge clk);
    check("to_ferr", 32'(fe_cnt - fe0), 1);
    check("to_empty", 32'(count), 0);
    sbq.push_back({2'b00, 8'h29});
    send(8'h29, 1'b0);
    wait_count("to_drain", 0);

    // Reset mid-frame with events queued.
    ready = 1'b0;
    send(8'h16, 1'b0);
    send(8'h1E, 1'b0);
    send(8'h26, 1'b0);
    wait_count("rst_pre_count", 3);
    ps2_bits(mkframe(8'h3D, 1'b0), 6);
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs", {valid, ext, brk, keycode, frame_err, ovf}, 0);
    check("rst_count", 32'(count), 0);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    sbq.push_back({2'b00, 8'h5A});
    send(8'h5A, 1'b0);
    wait_count("rst_after_count", 1);
    check("rst_after_head", {ext, brk, keycode}, {2'b00, 8'h5A});
    ready = 1'b1;
    wait_count("rst_drain", 0);
    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyrx.md
PS2_KEYRX -- requirements
Module: ps2_keyrx

Interface
REQ-001 Parameter DEPTH, default 8, event FIFO depth; power of 2, >= 2.
REQ-002 Parameter SYNC, default 2, synchroniser stages on kbdclk and dat; >= 2.
REQ-003 Parameter TIMEOUT, default 50000, clk cycles allowed between falling edges inside a frame.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 kbdclk  in  1  PS/2 clock line, asynchronous to clk, sampled as data.
REQ-007 dat  in  1  PS/2 data line, asynchronous to clk.
REQ-008 keycode  out  8  scan code of the FIFO head event; 0 when empty.
REQ-009 ext  out  1  head event was preceded by an E0 prefix; 0 when empty.
REQ-010 brk  out  1  head event is a release (preceded by an F0 prefix); 0 when empty.
REQ-011 valid  out  1  FIFO non-empty.
REQ-012 ready  in  1  consumer accept; pop occurs on a cycle with valid && ready.
REQ-013 count  out  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-014 frame_err  out  1  one-cycle pulse on a discarded frame.
REQ-015 ovf  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-016 kbdclk and dat each pass through SYNC flops clocked by clk; no logic is clocked by kbdclk.
REQ-017 A falling edge is detected in a cycle where the previous synchronised kbdclk is 1 and the current one is 0; synchronised dat is sampled in that cycle.
REQ-018 Receive FSM states: IDLE, SHIFT, CHECK.
REQ-019 IDLE -> SHIFT on a falling edge; that sample is bit 0 and the bit counter is set to 1.
REQ-020 SHIFT stores each sample at the bit counter index, LSB first; the 11th sample (bit 10) moves the FSM to CHECK.
REQ-021 Frame layout: bit0 start = 0, bits 1-8 data LSB first, bit9 odd parity over bits 1-9, bit10 stop = 1.
REQ-022 CHECK lasts exactly one cycle and returns to IDLE; a frame failing start, parity or stop produces frame_err, clears both prefix flags and pushes nothing.
REQ-023 In SHIFT, a cycle counter restarts on every edge; reaching TIMEOUT returns the FSM to IDLE, pulses frame_err and clears both prefix flags.
REQ-024 In CHECK, a good byte 8'hE0 sets ext_pend and a good byte 8'hF0 sets brk_pend; neither is pushed.
REQ-025 Any other good byte pushes the event {ext_pend, brk_pend, byte} and clears both pending flags in the same cycle.
REQ-026 The FIFO is first-word-fall-through: valid and head fields update in the cycle after a push into an empty FIFO, i.e. 2 clk after the cycle in which the 11th edge is detected.
REQ-027 A push while full and not popping drops the new event, pulses ovf, and leaves the FIFO contents unchanged.
REQ-028 A push and a pop in the same cycle are both performed, including at full and at one-entry occupancy; count is unchanged.
REQ-029 A pop while empty is ignored.
REQ-030 Read and write pointers wrap modulo DEPTH; count is held as an explicit counter, not derived from the pointers.

Reset
REQ-031 When rst_n = 0, asynchronously: FSM = IDLE, bit and timeout counters = 0, prefix flags = 0, FIFO empty, count = 0, and all outputs = 0.
REQ-032 The synchroniser flops reset to 1 (idle bus level) so that release of reset creates no false falling edge.
REQ-033 Reset asserted mid-frame discards the partial frame; the next frame after release is received normally.

Structure
REQ-034 Package ps2_pkg holds PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, the receive-state enum, and a 10-bit event typedef {ext, brk, code}.
REQ-035 The FIFO is the sub-module ps2_event_fifo (parameter DEPTH, event-width data, push/pop, count, full/empty), sharing the same clk and rst_n.

Verification
REQ-036 Send a frame carrying 8'h1C with correct parity, then pulse ready -> one event with keycode = 1C, ext = 0, brk = 0; after the pop valid = 0 and count = 0.
REQ-037 Send the sequence E0, F0, 74 -> exactly one event with keycode = 74, ext = 1, brk = 1; no frame_err.
REQ-038 Send 8'h1C with a flipped parity bit, then send 8'h32 -> one frame_err pulse; only event 32 is queued.
REQ-039 Hold ready = 0 and send DEPTH+1 valid codes -> count = DEPTH, ovf pulses once, and the head is the first code; then hold ready = 1 -> codes come out in order.
REQ-040 Stop kbdclk after 5 edges for TIMEOUT cycles -> frame_err pulses, FSM returns to IDLE, and the next full frame 8'h29 is received correctly.
REQ-041 Assert rst_n = 0 after the 6th edge with 3 events queued -> all outputs = 0 and count = 0; after release, 8'h5A is received as the only event.
